// File: rtl/lfsr_step_gen_if.sv
// Beat handshake bundle for lfsr_step_gen: the generator drives valid/data,
// the consumer drives ready.
interface lfsr_step_gen_if #(
  parameter int STEP = 8
);
  logic            out_valid;
  logic            out_ready;
  logic [STEP-1:0] out_data;

  modport master (output out_valid, output out_data, input out_ready);
  modport slave  (input out_valid, input out_data, output out_ready);
endinterface

// File: rtl/lfsr_step_gen.sv
// Galois LFSR advancing STEP steps per accepted beat, with load and an IDLE/RUN/RESEED FSM.
// Define LFSR_LOCKUP_RECOVER_EN to enable all-zero detection and automatic reseed.
module lfsr_step_gen #(
  parameter int              WIDTH = 16,
  parameter logic [WIDTH-1:0] POLY = 16'hB400,
  parameter int              STEP  = 8,
  parameter                  DIR   = "LSB",
  parameter logic [WIDTH-1:0] SEED = 16'hACE1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] seed_in,
  input  logic             din,
  lfsr_step_gen_if.master  beat,
  output logic [WIDTH-1:0] lfsr_state,
  output logic [7:0]       lockup_cnt
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    RESEED = 2'd2
  } state_t;

  localparam bit MSB_DIR = (DIR == "MSB");

  state_t           fsm;
  logic [STEP-1:0]  step_bits;
  logic [WIDTH-1:0] next_state;
  logic [WIDTH-1:0] step_s;
  logic             step_b;
  logic             step_fb;

  // NOTE: blocking assignments are intended here; step_s carries each unrolled
  // step into the next within one evaluation, and every variable gets a default
  // first so no latch is inferred.
  always_comb begin
    step_s    = lfsr_state;
    step_b    = 1'b0;
    step_fb   = 1'b0;
    step_bits = '0;
    for (int i = 0; i < STEP; i++) begin
      step_b       = MSB_DIR ? step_s[WIDTH-1] : step_s[0];
      step_bits[i] = step_b;
      // din perturbs only the feedback of the first step; the emitted bit stays
      // a pure function of lfsr_state so a stalled beat cannot change.
      step_fb      = (i == 0) ? (step_b ^ din) : step_b;
      step_s       = MSB_DIR ? (step_s << 1) : (step_s >> 1);
      if (step_fb) step_s = step_s ^ POLY;
    end
    next_state = step_s;
  end

  assign beat.out_data = step_bits;

  // NOTE: sequential state uses non-blocking assignments only, and the reset
  // branch is asynchronous (listed in the sensitivity list).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_state     <= SEED;
      fsm            <= IDLE;
      beat.out_valid <= 1'b0;
`ifdef LFSR_LOCKUP_RECOVER_EN
      lockup_cnt     <= '0;
`endif
    end else if (load) begin
      lfsr_state     <= seed_in;
      fsm            <= IDLE;
      beat.out_valid <= 1'b0;
    end else begin
      case (fsm)
        IDLE: begin
`ifdef LFSR_LOCKUP_RECOVER_EN
          if (lfsr_state == '0) begin
            fsm <= RESEED;
          end else
`endif
          if (en) begin
            fsm            <= RUN;
            beat.out_valid <= 1'b1;
          end
        end
        RUN: begin
          // A pending beat is held until accepted; en alone never withdraws it.
          if (beat.out_ready) begin
            lfsr_state <= next_state;
`ifdef LFSR_LOCKUP_RECOVER_EN
            if (next_state == '0) begin
              fsm            <= RESEED;
              beat.out_valid <= 1'b0;
            end else
`endif
            if (!en) begin
              fsm            <= IDLE;
              beat.out_valid <= 1'b0;
            end
          end
        end
        RESEED: begin
          lfsr_state <= SEED;
          fsm        <= IDLE;
`ifdef LFSR_LOCKUP_RECOVER_EN
          if (lockup_cnt != 8'hFF) lockup_cnt <= lockup_cnt + 8'd1;
`endif
        end
        default: begin
          fsm            <= IDLE;
          beat.out_valid <= 1'b0;
        end
      endcase
    end
  end

`ifndef LFSR_LOCKUP_RECOVER_EN
  assign lockup_cnt = '0;
`endif

endmodule

// File: doc/lfsr_step_gen.md
LFSR_STEP_GEN -- requirements
Module: lfsr_step_gen

Interface
REQ-001 Parameter WIDTH, default 16, LFSR register width; legal range 3..64.
REQ-002 Parameter POLY, default 16'hB400, Galois tap mask (x^16+x^14+x^13+x^11+1 for LSB direction).
REQ-003 Parameter STEP, default 8, LFSR steps advanced per accepted beat; legal range 1..WIDTH.
REQ-004 Parameter DIR, default "LSB", shift direction; legal values "LSB" (shift right) and "MSB" (shift left).
REQ-005 Parameter SEED, default 16'hACE1, reset value and lockup-recovery value; must be nonzero.
REQ-006 clk  input  1  sole clock; all state updates on rising edge.
REQ-007 rst  input  1  asynchronous, active-high reset.
REQ-008 en  input  1  run request; generator offers beats while high.
REQ-009 load  input  1  single-cycle pulse that loads seed_in into the LFSR.
REQ-010 seed_in  input  WIDTH  value captured on load.
REQ-011 din  input  1  bit XORed into the feedback of the first step of each accepted beat.
REQ-012 out_valid  output  1  out_data holds a beat.
REQ-013 out_ready  input  1  consumer accepts beat.
REQ-014 out_data  output  STEP  generated bits; bit 0 = first step's output bit.
REQ-015 lfsr_state  output  WIDTH  current LFSR register.
REQ-016 lockup_cnt  output  8  number of all-zero recoveries, saturating.

Function
REQ-017 Single LSB step SHALL be: b = s[0]; s' = (s >> 1) XOR (b ? POLY : 0); output bit = b.
REQ-018 Single MSB step SHALL be: b = s[WIDTH-1]; s' = (s << 1) XOR (b ? POLY : 0); output bit = b.
REQ-019 din SHALL be XORed into b of the first step only; all STEP steps SHALL be unrolled combinationally within one cycle.
REQ-020 out_data SHALL be the STEP output bits computed from the current lfsr_state; it is valid in the same cycle as out_valid.
REQ-021 The FSM SHALL have states IDLE, RUN and RESEED; reset state is IDLE.
REQ-022 IDLE -> RUN when en=1; out_valid=0 in IDLE; out_valid=1 in RUN.
REQ-023 In RUN, on out_valid & out_ready, lfsr_state SHALL advance by STEP steps at the next edge.
REQ-024 RUN -> IDLE only on a cycle with en=0 and (handshake or no beat pending); once asserted, out_valid SHALL NOT drop and out_data SHALL NOT change before the handshake, except on load or rst.
REQ-025 load SHALL take priority over all other events: lfsr_state <= seed_in, FSM -> IDLE, and any offered beat is discarded without advancing.
REQ-026 A nonzero lfsr_state SHALL never become zero through stepping alone; only load of zero or din injection can zero it.
REQ-027 Simultaneous load and handshake: load wins; the beat is discarded.

Reset
REQ-028 On rst: lfsr_state=SEED, FSM=IDLE, out_valid=0, lockup_cnt=0; out_data reflects SEED bits.
REQ-029 rst asserted mid-beat SHALL discard the beat with no partial advance.

Configuration
REQ-030 Macro LFSR_LOCKUP_RECOVER_EN defined: when lfsr_state==0 outside reset, the FSM SHALL enter RESEED for one cycle (out_valid=0), load SEED, increment lockup_cnt (saturating at 255), then return to IDLE.
REQ-031 Macro LFSR_LOCKUP_RECOVER_EN undefined: no zero detection, RESEED unreachable, lockup_cnt tied to 0, and a zero state persists, producing all-zero out_data.

Verification
REQ-032 Reset with defaults -> lfsr_state=16'hACE1, out_valid=0, lockup_cnt=0.
REQ-033 STEP=1, DIR="LSB", en=1, out_ready=1, din=0 -> first beat out_data=1; next lfsr_state=16'hE270; after 65535 accepted beats lfsr_state=16'hACE1 again.
REQ-034 STEP=8 and STEP=1 instances run in lockstep -> each STEP=8 beat equals 8 consecutive STEP=1 output bits, bit 0 first; states match every 8 beats.
REQ-035 out_ready held 0 for 5 cycles with en then dropped -> out_valid stays 1, out_data and lfsr_state are stable, and exactly one beat is accepted when out_ready rises.
REQ-036 load with seed_in=0 under LFSR_LOCKUP_RECOVER_EN -> one RESEED cycle, lfsr_state=SEED, lockup_cnt=1; without the macro -> lfsr_state stays 0 and out_data=0.
REQ-037 load asserted in the same cycle as a handshake -> lfsr_state=seed_in, out_valid=0 next cycle, and no advance.
